// File: rtl/usb_rx_pkt_decoder_if.sv
// Byte stream from the USB RX PHY into the packet decoder, plus the decoded
// packet fields and payload stream handed on to the protocol state machine.
interface usb_rx_pkt_decoder_if;
    logic        rx_active;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [3:0]  pkt_pid;
    logic [6:0]  pkt_addr;
    logic [3:0]  pkt_endp;
    logic [10:0] pkt_frame;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        pkt_done;
    logic        pkt_ok;
    logic        pid_err;
    logic        crc_err;
    logic        len_err;

    modport master (
        output rx_active, rx_valid, rx_data,
        input  pkt_pid, pkt_addr, pkt_endp, pkt_frame, out_valid, out_data,
        input  pkt_done, pkt_ok, pid_err, crc_err, len_err
    );

    modport slave (
        input  rx_active, rx_valid, rx_data,
        output pkt_pid, pkt_addr, pkt_endp, pkt_frame, out_valid, out_data,
        output pkt_done, pkt_ok, pid_err, crc_err, len_err
    );
endinterface

// File: rtl/usb_rx_pkt_decoder.sv
// USB receive packet decoder: PID check, CRC5/CRC16 check, token field
// extraction and payload forwarding with the trailing CRC bytes stripped.
module usb_rx_pkt_decoder #(
    parameter int MAX_PAYLOAD = 1023
) (
    input logic clkout2,
    input logic reset,
    usb_rx_pkt_decoder_if.slave bus
);
    typedef enum logic [2:0] {SKIP, IDLE, PID, TOKEN, DATA, HS, DONE} state_t;

    localparam logic [10:0] MAX_CNT = 11'(MAX_PAYLOAD + 2);

    state_t      state;
    logic [10:0] byteCnt;
    logic [4:0]  crc5;
    logic [15:0] crc16;
    logic [1:0]  pktClass;
    logic        pidErr;
    logic [7:0]  pidByte, tokB1, tokB2;
    logic [7:0]  hold_p0, hold_p1;
    logic        lenOk, crcBad;

    function automatic logic [4:0] crc5Byte(input logic [4:0] c, input logic [7:0] b);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 5'h14;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [15:0] crc16Byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // End-of-packet verdict, evaluated from the accumulated count and CRC residues
    always_comb begin
        lenOk  = 1'b0;
        crcBad = 1'b0;
        case (pktClass)
            2'b01: begin
                lenOk  = (byteCnt == 11'd2);
                crcBad = (crc5 != 5'h06);
            end
            2'b11: begin
                lenOk  = (byteCnt >= 11'd2) && (byteCnt <= MAX_CNT);
                crcBad = (byteCnt >= 11'd2) && (crc16 != 16'hB001);
            end
            default: lenOk = (byteCnt == 11'd0);
        endcase
    end

    always_ff @(posedge clkout2 or posedge reset) begin
        if (reset) begin
            state         <= SKIP;
            byteCnt       <= '0;
            crc5          <= 5'h1F;
            crc16         <= 16'hFFFF;
            pktClass      <= 2'b00;
            pidErr        <= 1'b0;
            bus.pkt_pid   <= '0;
            bus.pkt_addr  <= '0;
            bus.pkt_endp  <= '0;
            bus.pkt_frame <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.pkt_done  <= 1'b0;
            bus.pkt_ok    <= 1'b0;
            bus.pid_err   <= 1'b0;
            bus.crc_err   <= 1'b0;
            bus.len_err   <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.pkt_done  <= 1'b0;
            case (state)
                SKIP: if (!bus.rx_active) state <= IDLE;
                IDLE: begin
                    byteCnt <= '0;
                    crc5    <= 5'h1F;
                    crc16   <= 16'hFFFF;
                    if (bus.rx_valid && bus.rx_active) state <= PID;
                end
                PID: begin
                    pidErr   <= (pidByte[7:4] != ~pidByte[3:0]);
                    pktClass <= pidByte[1:0];
                    if (!bus.rx_active)            state <= DONE;
                    else if (pidByte[1:0] == 2'b01) state <= TOKEN;
                    else if (pidByte[1:0] == 2'b11) state <= DATA;
                    else                            state <= HS;
                end
                TOKEN, DATA, HS: begin
                    // A byte arriving with the fall of rx_active still belongs to this packet
                    if (bus.rx_valid) begin
                        if (byteCnt != 11'h7FF) byteCnt <= byteCnt + 11'd1;
                        if (state == TOKEN && byteCnt < 11'd2) crc5 <= crc5Byte(crc5, bus.rx_data);
                        if (state == DATA) begin
                            crc16 <= crc16Byte(crc16, bus.rx_data);
                            if (byteCnt >= 11'd2) begin
                                bus.out_valid <= 1'b1;
                                bus.out_data  <= hold_p1;
                            end
                        end
                    end
                    if (!bus.rx_active) state <= DONE;
                end
                DONE: begin
                    bus.pkt_done <= 1'b1;
                    bus.pkt_pid  <= pidByte[3:0];
                    bus.pid_err  <= pidErr;
                    bus.crc_err  <= crcBad;
                    bus.len_err  <= !lenOk;
                    bus.pkt_ok   <= !pidErr && !crcBad && lenOk;
                    if (pktClass == 2'b01 && byteCnt == 11'd2) begin
                        bus.pkt_addr  <= tokB1[6:0];
                        bus.pkt_endp  <= {tokB2[2:0], tokB1[7]};
                        bus.pkt_frame <= {tokB2[2:0], tokB1};
                    end
                    state <= IDLE;
                end
                default: state <= SKIP;
            endcase
        end
    end

    // Byte capture: PID, token bytes and the 2-deep payload hold-back
    always_ff @(posedge clkout2) begin
        if (state == IDLE && bus.rx_valid && bus.rx_active) pidByte <= bus.rx_data;
        if (state == TOKEN && bus.rx_valid) begin
            if (byteCnt == 11'd0) tokB1 <= bus.rx_data;
            if (byteCnt == 11'd1) tokB2 <= bus.rx_data;
        end
        if (state == DATA && bus.rx_valid) begin
            hold_p1 <= hold_p0;
            hold_p0 <= bus.rx_data;
        end
    end
endmodule

// File: tb/tb_usb_rx_pkt_decoder.sv
// Directed bench for usb_rx_pkt_decoder: tokens, data, handshakes, reset and
// framing corner cases with hand-computed expectations.
module tb_usb_rx_pkt_decoder;
    logic clkout2 = 1'b0;
    logic reset   = 1'b1;
    int   checks  = 0;
    int   passed  = 0;
    int   doneCnt = 0;
    logic [7:0] outQ[$];
    logic [7:0] pktBuf[16];

    usb_rx_pkt_decoder_if bus();

    usb_rx_pkt_decoder #(.MAX_PAYLOAD(1023)) dut (
        .clkout2(clkout2),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clkout2 = ~clkout2;

    always @(negedge clkout2) begin
        if (!reset) begin
            if (bus.out_valid) outQ.push_back(bus.out_data);
            if (bus.pkt_done) doneCnt++;
        end
    end

    task automatic step();
        @(posedge clkout2);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) step();
    endtask

    task automatic sendByte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        step();
        bus.rx_valid = 1'b0;
        repeat (7) step();
    endtask

    task automatic sendPkt(input int len, input bit coincident);
        bus.rx_active = 1'b1;
        step();
        for (int i = 0; i < len; i++) begin
            if (coincident && i == len - 1) begin
                bus.rx_valid  = 1'b1;
                bus.rx_data   = pktBuf[i];
                bus.rx_active = 1'b0;
                step();
                bus.rx_valid  = 1'b0;
            end else begin
                sendByte(pktBuf[i]);
            end
        end
        bus.rx_active = 1'b0;
    endtask

    task automatic test_reset();
        bus.rx_active = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        reset = 1'b1;
        settle(3);
        checks++;
        if ({bus.pkt_pid, bus.pkt_addr, bus.pkt_endp, bus.pkt_frame, bus.out_valid, bus.out_data,
             bus.pkt_done, bus.pkt_ok, bus.pid_err, bus.crc_err, bus.len_err} !== 44'h0)
            $display("FAIL reset_outputs: got pid=%h ok=%b done=%b, want all zero",
                     bus.pkt_pid, bus.pkt_ok, bus.pkt_done);
        else passed++;
        reset = 1'b0;
        settle(2);
    endtask

    task automatic test_in_token();
        int d0, o0;
        d0 = doneCnt; o0 = outQ.size();
        pktBuf[0] = 8'h69; pktBuf[1] = 8'h00; pktBuf[2] = 8'h10;
        sendPkt(3, 0);
        settle(12);
        checks++; if (doneCnt - d0 !== 1) $display("FAIL in_done: got %0d want 1", doneCnt - d0); else passed++;
        checks++; if (bus.pkt_pid !== 4'h9) $display("FAIL in_pid: got %h want 9", bus.pkt_pid); else passed++;
        checks++; if ({bus.pkt_addr, bus.pkt_endp} !== 11'h0) $display("FAIL in_addr_endp: got %h/%h want 0/0", bus.pkt_addr, bus.pkt_endp); else passed++;
        checks++; if (bus.pkt_ok !== 1'b1) $display("FAIL in_ok: got %b want 1", bus.pkt_ok); else passed++;
        checks++; if (outQ.size() - o0 !== 0) $display("FAIL in_no_payload: got %0d want 0", outQ.size() - o0); else passed++;
    endtask

    task automatic test_setup_crc();
        pktBuf[0] = 8'h2D; pktBuf[1] = 8'h00; pktBuf[2] = 8'h10;
        sendPkt(3, 0);
        settle(12);
        checks++; if ({bus.pkt_pid, bus.pkt_ok} !== 5'b1101_1) $display("FAIL setup_ok: got pid=%h ok=%b want D/1", bus.pkt_pid, bus.pkt_ok); else passed++;
        pktBuf[2] = 8'h11;
        sendPkt(3, 0);
        settle(12);
        checks++; if (bus.crc_err !== 1'b1) $display("FAIL setup_crc_err: got %b want 1", bus.crc_err); else passed++;
        checks++; if (bus.pkt_ok !== 1'b0) $display("FAIL setup_bad_ok: got %b want 0", bus.pkt_ok); else passed++;
    endtask

    task automatic test_data0();
        int d0, o0;
        logic [7:0] exp[8];
        exp = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
        pktBuf[0] = 8'hC3; pktBuf[1] = 8'h80; pktBuf[2] = 8'h06; pktBuf[3] = 8'h00;
        pktBuf[4] = 8'h01; pktBuf[5] = 8'h00; pktBuf[6] = 8'h00; pktBuf[7] = 8'h40;
        pktBuf[8] = 8'h00; pktBuf[9] = 8'hDD; pktBuf[10] = 8'h94;
        d0 = doneCnt; o0 = outQ.size();
        sendPkt(11, 0);
        settle(12);
        checks++; if (outQ.size() - o0 !== 8) $display("FAIL data0_count: got %0d want 8", outQ.size() - o0); else passed++;
        for (int i = 0; i < 8; i++) begin
            if (o0 + i < outQ.size()) begin
                checks++;
                if (outQ[o0 + i] !== exp[i]) $display("FAIL data0_byte%0d: got %h want %h", i, outQ[o0 + i], exp[i]);
                else passed++;
            end
        end
        checks++; if (doneCnt - d0 !== 1) $display("FAIL data0_done: got %0d want 1", doneCnt - d0); else passed++;
        checks++; if ({bus.pkt_pid, bus.crc_err, bus.len_err, bus.pkt_ok} !== 7'b0011_001)
            $display("FAIL data0_status: got pid=%h crc=%b len=%b ok=%b want 3/0/0/1", bus.pkt_pid, bus.crc_err, bus.len_err, bus.pkt_ok);
        else passed++;
    endtask

    task automatic test_token_fields();
        pktBuf[0] = 8'h2D; pktBuf[1] = 8'h95; pktBuf[2] = 8'h03;
        sendPkt(3, 0);
        settle(12);
        checks++; if (bus.pkt_addr !== 7'h15) $display("FAIL tok_addr: got %h want 15", bus.pkt_addr); else passed++;
        checks++; if (bus.pkt_endp !== 4'h7) $display("FAIL tok_endp: got %h want 7", bus.pkt_endp); else passed++;
        checks++; if (bus.pkt_frame !== 11'h395) $display("FAIL tok_frame: got %h want 395", bus.pkt_frame); else passed++;
        checks++; if (bus.len_err !== 1'b0) $display("FAIL tok_len: got %b want 0", bus.len_err); else passed++;
    endtask

    task automatic test_zero_len();
        int o0;
        o0 = outQ.size();
        pktBuf[0] = 8'h4B; pktBuf[1] = 8'h00; pktBuf[2] = 8'h00;
        sendPkt(3, 0);
        settle(12);
        checks++; if (outQ.size() - o0 !== 0) $display("FAIL zlp_payload: got %0d want 0", outQ.size() - o0); else passed++;
        checks++; if ({bus.pkt_pid, bus.pkt_ok} !== 5'b1011_1) $display("FAIL zlp_ok: got pid=%h ok=%b want B/1", bus.pkt_pid, bus.pkt_ok); else passed++;
    endtask

    task automatic test_handshake();
        pktBuf[0] = 8'hD2;
        sendPkt(1, 0);
        settle(12);
        checks++; if ({bus.pkt_pid, bus.pkt_ok} !== 5'b0010_1) $display("FAIL ack_ok: got pid=%h ok=%b want 2/1", bus.pkt_pid, bus.pkt_ok); else passed++;
        pktBuf[1] = 8'h00;
        sendPkt(2, 0);
        settle(12);
        checks++; if ({bus.len_err, bus.crc_err, bus.pid_err, bus.pkt_ok} !== 4'b1000)
            $display("FAIL ack_len: got len=%b crc=%b pid=%b ok=%b want 1/0/0/0", bus.len_err, bus.crc_err, bus.pid_err, bus.pkt_ok);
        else passed++;
        pktBuf[0] = 8'hD3;
        sendPkt(1, 0);
        settle(12);
        checks++; if ({bus.pkt_pid, bus.pid_err, bus.pkt_ok} !== 6'b0011_10)
            $display("FAIL badpid: got pid=%h perr=%b ok=%b want 3/1/0", bus.pkt_pid, bus.pid_err, bus.pkt_ok);
        else passed++;
        checks++; if ({bus.len_err, bus.crc_err} !== 2'b10)
            $display("FAIL badpid_merge: got len=%b crc=%b want 1/0", bus.len_err, bus.crc_err);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = doneCnt;
        pktBuf[0] = 8'hD2;
        sendPkt(1, 0);
        settle(2);
        bus.rx_active = 1'b1;
        bus.rx_valid  = 1'b1;
        bus.rx_data   = 8'h5A;
        step();
        bus.rx_valid  = 1'b0;
        settle(3);
        bus.rx_active = 1'b0;
        settle(12);
        checks++; if (doneCnt - d0 !== 2) $display("FAIL b2b_done: got %0d want 2", doneCnt - d0); else passed++;
        checks++; if ({bus.pkt_pid, bus.pkt_ok} !== 5'b1010_1) $display("FAIL b2b_pid: got pid=%h ok=%b want A/1", bus.pkt_pid, bus.pkt_ok); else passed++;
    endtask

    task automatic test_reset_mid();
        int d0, o0;
        bus.rx_active = 1'b1;
        step();
        sendByte(8'hC3); sendByte(8'h80); sendByte(8'h06); sendByte(8'h00);
        #2 reset = 1'b1;
        #3;
        checks++;
        if ({bus.pkt_pid, bus.pkt_addr, bus.pkt_endp, bus.pkt_frame, bus.out_valid, bus.out_data,
             bus.pkt_done, bus.pkt_ok, bus.pid_err, bus.crc_err, bus.len_err} !== 44'h0)
            $display("FAIL midreset_outputs: got pid=%h ok=%b frame=%h, want all zero",
                     bus.pkt_pid, bus.pkt_ok, bus.pkt_frame);
        else passed++;
        step();
        reset = 1'b0;
        d0 = doneCnt; o0 = outQ.size();
        sendByte(8'h01); sendByte(8'h00); sendByte(8'h00); sendByte(8'h40);
        sendByte(8'h00); sendByte(8'hDD); sendByte(8'h94);
        bus.rx_active = 1'b0;
        settle(12);
        checks++; if (doneCnt - d0 !== 0) $display("FAIL midreset_nodone: got %0d want 0", doneCnt - d0); else passed++;
        checks++; if (outQ.size() - o0 !== 0) $display("FAIL midreset_nopayload: got %0d want 0", outQ.size() - o0); else passed++;
        pktBuf[0] = 8'h69; pktBuf[1] = 8'h00; pktBuf[2] = 8'h10;
        sendPkt(3, 0);
        settle(12);
        checks++; if (doneCnt - d0 !== 1) $display("FAIL midreset_next_done: got %0d want 1", doneCnt - d0); else passed++;
        checks++; if ({bus.pkt_pid, bus.pkt_ok} !== 5'b1001_1) $display("FAIL midreset_next: got pid=%h ok=%b want 9/1", bus.pkt_pid, bus.pkt_ok); else passed++;
    endtask

    task automatic test_active_pulse();
        int d0;
        d0 = doneCnt;
        bus.rx_active = 1'b1;
        settle(5);
        bus.rx_active = 1'b0;
        settle(12);
        checks++; if (doneCnt - d0 !== 0) $display("FAIL pulse_nodone: got %0d want 0", doneCnt - d0); else passed++;
    endtask

    task automatic test_coincident();
        int d0;
        d0 = doneCnt;
        pktBuf[0] = 8'h69; pktBuf[1] = 8'h00; pktBuf[2] = 8'h10;
        sendPkt(3, 1);
        settle(12);
        checks++; if (doneCnt - d0 !== 1) $display("FAIL coinc_done: got %0d want 1", doneCnt - d0); else passed++;
        checks++; if ({bus.pkt_ok, bus.len_err} !== 2'b10) $display("FAIL coinc_ok: got ok=%b len=%b want 1/0", bus.pkt_ok, bus.len_err); else passed++;
    endtask

    initial begin
        test_reset();
        test_in_token();
        test_setup_crc();
        test_data0();
        test_token_fields();
        test_zero_len();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        test_active_pulse();
        test_coincident();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
